// File: rtl/axi_rd_data_ctrl.sv
// AXI4 read-data channel controller: forwards one R burst into a write-side FIFO,
// validates RID/RRESP/beat count against the issued AR, and drains errored bursts.
module axi_rd_data_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  go,
  input  logic [ID_WIDTH-1:0]   expected_id,
  input  logic [LEN_WIDTH-1:0]  expected_len,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  input  logic                  fifo_ready,
  output logic                  last_transfer,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            error_code,
  output logic [LEN_WIDTH:0]    beat_count,
  output logic [ID_WIDTH-1:0]   transaction_ID,
  input  logic [ID_WIDTH-1:0]   RID,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  typedef enum logic [2:0] {IDLE, ACTIVE, DRAIN, ERROR, DONE} state_t;

  localparam logic [LEN_WIDTH:0] CNT_MAX = {1'b1, {LEN_WIDTH{1'b0}}};

  state_t               state_reg, state_next;
  logic [LEN_WIDTH-1:0] len_reg, len_next;
  logic [ID_WIDTH-1:0]  tid_reg, tid_next;
  logic [LEN_WIDTH:0]   cnt_reg, cnt_next;
  logic [2:0]           code_reg, code_next;
  logic                 done_reg, error_reg;
  logic                 acc;
  logic [2:0]           beat_err;
  logic [LEN_WIDTH:0]   len_ext;

  assign len_ext = {1'b0, len_reg};
  assign acc     = RVALID & RREADY;

  // Error classification of the presented beat, highest priority first;
  // compares against the count of beats accepted before this one.
  always_comb begin
    beat_err = 3'd0;
    if (RRESP == 2'b10)                  beat_err = 3'd1;
    else if (RRESP == 2'b11)             beat_err = 3'd2;
    else if (RID != tid_reg)             beat_err = 3'd3;
    else if (RLAST && cnt_reg < len_ext) beat_err = 3'd4;
    else if (!RLAST && cnt_reg == len_ext) beat_err = 3'd5;
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    tid_next      = tid_reg;
    cnt_next      = cnt_reg;
    code_next     = code_reg;
    RREADY        = 1'b0;
    data_valid    = 1'b0;
    last_transfer = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (go) begin
          tid_next   = expected_id;
          len_next   = expected_len;
          cnt_next   = '0;
          code_next  = 3'd0;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        RREADY = fifo_ready;
        if (acc) begin
          if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + 1'b1;
          if (beat_err != 3'd0) begin
            code_next  = beat_err;
            state_next = RLAST ? ERROR : DRAIN;
          end else begin
            data_valid = 1'b1;
            if (RLAST) begin
              last_transfer = 1'b1;
              state_next    = DONE;
            end
          end
        end
      end
      DRAIN: begin
        // Swallow the rest of the burst so the interconnect is never stalled.
        RREADY = 1'b1;
        if (RVALID && RLAST) state_next = ERROR;
      end
      ERROR, DONE: begin
        if (!go) begin
          tid_next   = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      tid_reg   <= '0;
      cnt_reg   <= '0;
      code_reg  <= 3'd0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      tid_reg   <= tid_next;
      cnt_reg   <= cnt_next;
      code_reg  <= code_next;
      done_reg  <= (state_next == DONE);
      error_reg <= (state_next == ERROR);
    end
  end

  assign data           = RDATA;
  assign done           = done_reg;
  assign error          = error_reg;
  assign error_code     = code_reg;
  assign beat_count     = cnt_reg;
  assign transaction_ID = tid_reg;

endmodule

// File: tb/tb_axi_rd_data_ctrl.sv
// Directed bench for axi_rd_data_ctrl: clean, backpressured and errored bursts,
// asynchronous reset mid-burst and the go/done release handshake.
module tb_axi_rd_data_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        go;
  logic [3:0]  expected_id;
  logic [7:0]  expected_len;
  logic [31:0] data;
  logic        data_valid;
  logic        fifo_ready;
  logic        last_transfer;
  logic        done;
  logic        error;
  logic [2:0]  error_code;
  logic [8:0]  beat_count;
  logic [3:0]  transaction_ID;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  axi_rd_data_ctrl #(.DATA_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(8)) dut (
    .clk(clk), .resetn(resetn), .go(go),
    .expected_id(expected_id), .expected_len(expected_len),
    .data(data), .data_valid(data_valid), .fifo_ready(fifo_ready),
    .last_transfer(last_transfer), .done(done), .error(error),
    .error_code(error_code), .beat_count(beat_count),
    .transaction_ID(transaction_ID),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One R-channel cycle: drive on the falling edge, let combinational outputs settle.
  task automatic drive(input logic v, input logic [3:0] id, input logic [1:0] resp,
                       input logic last, input logic fr, input logic [31:0] d);
    @(negedge clk);
    RVALID = v; RID = id; RRESP = resp; RLAST = last; fifo_ready = fr; RDATA = d;
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 4'd0, 2'b00, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic start(input logic [3:0] id, input logic [7:0] len);
    @(negedge clk);
    go = 1'b1; expected_id = id; expected_len = len;
    RVALID = 1'b0; RLAST = 1'b0;
  endtask

  task automatic release_go();
    @(negedge clk);
    go = 1'b0; RVALID = 1'b0;
  endtask

  initial begin
    int acc_n;
    resetn = 1'b0; go = 1'b0; expected_id = '0; expected_len = '0;
    fifo_ready = 1'b1; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
    #1;
    check("rst_rready", RREADY, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_code", error_code, 0);
    check("rst_count", beat_count, 0);
    check("rst_tid", transaction_ID, 0);
    @(negedge clk); resetn = 1'b1;

    // Clean burst, 4 beats
    start(4'd5, 8'd3);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'd5, 2'b00, k == 3, 1'b1, 32'hA0 + k);
      if (k == 0) check("t1_tid", transaction_ID, 5);
      check("t1_dv", data_valid, 1);
      check("t1_data", data, 32'hA0 + k);
      check("t1_last", last_transfer, k == 3);
    end
    idle_cycle();
    check("t1_done", done, 1);
    check("t1_error", error, 0);
    check("t1_count", beat_count, 4);
    check("t1_code", error_code, 0);
    check("t1_rready_done", RREADY, 0);

    // go held high: done stays asserted
    for (int c = 0; c < 10; c++) begin
      idle_cycle();
      check("hold_done", done, 1);
    end
    release_go();
    drive(1'b1, 4'd5, 2'b00, 1'b0, 1'b1, 32'h0);
    check("rel_done", done, 0);
    check("rel_tid", transaction_ID, 0);
    check("rel_rready_idle", RREADY, 0);

    // Backpressure: fifo_ready 1,0,0 repeating
    start(4'd5, 8'd3);
    acc_n = 0;
    for (int c = 0; c < 20 && acc_n < 4; c++) begin
      drive(1'b1, 4'd5, 2'b00, acc_n == 3, (c % 3) == 0, 32'hB0 + acc_n);
      check("bp_rready", RREADY, (c % 3) == 0);
      check("bp_dv", data_valid, (c % 3) == 0);
      if (data_valid) begin
        check("bp_data", data, 32'hB0 + acc_n);
        acc_n++;
      end
    end
    check("bp_accepted", acc_n, 4);
    idle_cycle();
    check("bp_done", done, 1);
    check("bp_count", beat_count, 4);
    release_go();

    // SLVERR on beat 3 of 8, then drain with fifo_ready low
    start(4'd5, 8'd7);
    drive(1'b1, 4'd5, 2'b00, 1'b0, 1'b1, 32'hC0);
    drive(1'b1, 4'd5, 2'b00, 1'b0, 1'b1, 32'hC1);
    drive(1'b1, 4'd5, 2'b10, 1'b0, 1'b1, 32'hC2);
    check("slv_dv", data_valid, 0);
    for (int k = 4; k <= 8; k++) begin
      drive(1'b1, 4'd5, 2'b00, k == 8, 1'b0, 32'hC0 + k);
      check("slv_drain_rready", RREADY, 1);
      check("slv_drain_dv", data_valid, 0);
    end
    idle_cycle();
    check("slv_error", error, 1);
    check("slv_done", done, 0);
    check("slv_code", error_code, 1);
    check("slv_count", beat_count, 3);
    release_go();
    idle_cycle();
    check("slv_error_clr", error, 0);

    // RID mismatch on beat 1
    start(4'd5, 8'd3);
    drive(1'b1, 4'd6, 2'b00, 1'b0, 1'b1, 32'hD0);
    check("rid_dv", data_valid, 0);
    for (int k = 2; k <= 4; k++) drive(1'b1, 4'd5, 2'b00, k == 4, 1'b1, 32'hD0 + k);
    idle_cycle();
    check("rid_error", error, 1);
    check("rid_code", error_code, 3);
    check("rid_count", beat_count, 1);
    release_go();

    // Early RLAST on beat 2 of 4
    start(4'd5, 8'd3);
    drive(1'b1, 4'd5, 2'b00, 1'b0, 1'b1, 32'hE0);
    drive(1'b1, 4'd5, 2'b00, 1'b1, 1'b1, 32'hE1);
    check("early_dv", data_valid, 0);
    check("early_last", last_transfer, 0);
    idle_cycle();
    check("early_error", error, 1);
    check("early_code", error_code, 4);
    check("early_count", beat_count, 2);
    release_go();

    // Missing RLAST on beat 2 of 2, drain until RLAST
    start(4'd5, 8'd1);
    drive(1'b1, 4'd5, 2'b00, 1'b0, 1'b1, 32'hF0);
    drive(1'b1, 4'd5, 2'b00, 1'b0, 1'b1, 32'hF1);
    check("miss_dv", data_valid, 0);
    drive(1'b1, 4'd5, 2'b00, 1'b1, 1'b0, 32'hF2);
    check("miss_drain_rready", RREADY, 1);
    idle_cycle();
    check("miss_error", error, 1);
    check("miss_code", error_code, 5);
    check("miss_count", beat_count, 2);
    release_go();
    idle_cycle();

    // Asynchronous reset mid-burst
    start(4'd5, 8'd3);
    drive(1'b1, 4'd5, 2'b00, 1'b0, 1'b1, 32'h10);
    drive(1'b1, 4'd5, 2'b00, 1'b0, 1'b1, 32'h11);
    drive(1'b1, 4'd5, 2'b00, 1'b0, 1'b1, 32'h12);
    check("ar_pre_rready", RREADY, 1);
    check("ar_pre_count", beat_count, 2);
    #1 resetn = 1'b0;
    #1;
    check("ar_rready", RREADY, 0);
    check("ar_dv", data_valid, 0);
    check("ar_count", beat_count, 0);
    check("ar_tid", transaction_ID, 0);
    check("ar_done", done, 0);
    check("ar_error", error, 0);
    @(negedge clk);
    go = 1'b0; resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'd5, 2'b00, 1'b0, 1'b1, 32'h20);
      check("ar_idle_rready", RREADY, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
